alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (3-bit op, 32-bit operands/result) between two requesters.
- Each requester issues through a valid/ready handshake and gets back one result pulse.
- Sits between the ALU and its clients, e.g. a datapath port and a debug/test port.
- Round-robin fairness; one operation in flight at a time.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 3, ALU op-code width.
- ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 this cycle.
- req0_op  in  OP_W  requester 0 op-code.
- req0_a  in  DATA_W  requester 0 operand A.
- req0_b  in  DATA_W  requester 0 operand B.
- rsp0_valid  out  1  one-cycle pulse: result for requester 0.
- rsp0_result  out  DATA_W  result for requester 0.
- req1_*, rsp1_*  same as requester 0, for requester 1.
- alu_op  out  OP_W  to ALU.
- alu_a  out  DATA_W  to ALU.
- alu_b  out  DATA_W  to ALU.
- alu_result  in  DATA_W  from ALU.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, priority pointer=0 (requester 0 favoured).
  - All outputs 0: req*_ready, rsp*_valid, rsp*_result, alu_op/a/b, busy.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = only valid requester; if both valid, the one named by the priority pointer.
  - reqN_ready = (state==IDLE) && grant==N. Combinational from valid; at most one ready high.
  - Transfer on reqN_valid && reqN_ready: latch op/a/b and grant id, load counter=ALU_LAT-1, go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - alu_op/a/b driven from latched registers, stable for ALU_LAT cycles.
  - Counter decrements each cycle; when it reaches 0, capture alu_result into rspN_result and go to RESP.
- RESP:
  - rspN_valid=1 for exactly one cycle; the other requester's rsp_valid stays 0.
  - Priority pointer set to the other requester. Return to IDLE.
- rspN_result holds its value until that requester's next response; no response backpressure.
- Latency: accept at cycle t -> rsp_valid at cycle t+ALU_LAT+1. Throughput: one op per ALU_LAT+2 cycles.
- alu_* outputs hold their last values outside EXEC (no toggling in IDLE).
- Requester changes valid/operands while not ready: ignored; only the transfer cycle is sampled.
- Single requester: served back-to-back regardless of pointer. Pointer still updates after each grant.
- Reset mid-operation: operation dropped, no response, pointer back to 0.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - Each increments on its requester's transfer and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_arb_pkg:
  - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - ALU op-code constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_NOT=3'b100, ALU_SLT=3'b101.
  - Default widths.
- One natural sub-module: rr_arb2 (combinational 2-way round-robin grant from valid pair and pointer). Pointer register stays in alu_arbiter.

Test Plan (bench drives a behavioural ALU with ALU_LAT=1, ADD=000, SUB=001):
1. Req0 only, ADD a=5 b=7, after reset -> req0_ready same cycle; rsp0_valid pulse 2 cycles after transfer with rsp0_result=12; rsp1_valid stays 0.
2. Both valid from reset: req0 SUB 10-3, req1 ADD 1+1 -> req0 served first (rsp0_result=7); req1 accepted in the next IDLE (rsp1_result=2); alternation continues while both are held valid.
3. Req1 only, 3 back-to-back ops (ADD 1+2, 2+3, 3+4) -> results 3, 5, 7, one every 3 cycles; req0_ready never high.
4. rst asserted during EXEC -> outputs 0 asynchronously; no rsp pulse after release; next simultaneous request grants req0.
5. ALU_LAT=4, ADD 0xFFFFFFFF+1 -> alu_* stable 4 cycles; rsp result 0x00000000 at transfer+5.
6. ALU_ARB_STATS_EN defined, 3 req0 and 2 req1 transfers -> grant_cnt0=3, grant_cnt1=2; reset clears both.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// State encoding, ALU op-codes and default widths.
package alu_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOT = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; zero latency, no state.
// A lone valid always wins; on a tie the pointer picks (0 -> requester 0).
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one op in flight,
// result pulse ALU_LAT+1 cycles after accept. ALU_ARB_STATS_EN adds grant counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t            state;
    logic              ptr;
    logic              gid;
    logic [3:0]        cnt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        grant;
    logic              idle_ok;
    logic              xfer0;
    logic              xfer1;

    rr_arb2 u_rr (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign idle_ok    = (state == IDLE) && !rst;
    assign req0_ready = idle_ok && grant[0];
    assign req1_ready = idle_ok && grant[1];
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            gid         <= 1'b0;
            cnt         <= 4'd0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_result <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer0 || xfer1) begin
                        gid   <= xfer1;
                        op_q  <= xfer1 ? req1_op : req0_op;
                        a_q   <= xfer1 ? req1_a  : req0_a;
                        b_q   <= xfer1 ? req1_b  : req0_b;
                        cnt   <= CNT_INIT;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        if (gid) begin
                            rsp1_valid  <= 1'b1;
                            rsp1_result <= alu_result;
                        end else begin
                            rsp0_valid  <= 1'b1;
                            rsp0_result <= alu_result;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ptr   <= other_req(gid);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else begin
            if (xfer0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (xfer1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule
